// File: rtl/compact_instruction_packer.sv
// Rewrites RV32I instructions that have an RVC equivalent into 16-bit parcels and packs
// the resulting 16/32-bit parcels little-endian into an aligned 32-bit word stream.
module compact_instruction_packer #(
  parameter bit ENABLE_COMPACTION = 1'b1,
  parameter int COUNTER_WIDTH     = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [31:0]              inInstruction,
  input  logic                     flush,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [31:0]              outWord,
  output logic                     illegalInput,
  output logic [COUNTER_WIDTH-1:0] compactedCount
);

  typedef enum logic {EMPTY, HALF} packState;

  packState    state;
  logic [15:0] hold;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic       rdC, rs1C, rs2C, immSmall, lwOffOk, swOffOk;
  logic [5:0] imm6;
  logic [4:0] offL, offS;

  assign opcode = inInstruction[6:0];
  assign rd     = inInstruction[11:7];
  assign funct3 = inInstruction[14:12];
  assign rs1    = inInstruction[19:15];
  assign rs2    = inInstruction[24:20];
  assign funct7 = inInstruction[31:25];

  assign rdC  = (rd[4:3] == 2'b01);
  assign rs1C = (rs1[4:3] == 2'b01);
  assign rs2C = (rs2[4:3] == 2'b01);

  // I-immediate fits in 6 signed bits when imm[11:5] is pure sign extension
  assign immSmall = (&inInstruction[31:25]) | ~(|inInstruction[31:25]);
  assign imm6     = inInstruction[25:20];

  // word offsets 0..124: off[6:2] kept, everything above and below must be zero
  assign offL    = inInstruction[26:22];
  assign offS    = {inInstruction[26:25], inInstruction[11:9]};
  assign lwOffOk = (inInstruction[31:27] == 5'd0) && (inInstruction[21:20] == 2'd0);
  assign swOffOk = (inInstruction[31:27] == 5'd0) && (inInstruction[8:7] == 2'd0);

  logic        canCompress;
  logic [15:0] cParcel;
  logic        aluHit;
  logic [1:0]  aluOp;

  always_comb begin
    aluHit = 1'b0;
    aluOp  = 2'b00;
    if (funct7 == 7'b0100000 && funct3 == 3'b000) begin aluHit = 1'b1; aluOp = 2'b00; end
    else if (funct7 == 7'b0000000 && funct3 == 3'b100) begin aluHit = 1'b1; aluOp = 2'b01; end
    else if (funct7 == 7'b0000000 && funct3 == 3'b110) begin aluHit = 1'b1; aluOp = 2'b10; end
    else if (funct7 == 7'b0000000 && funct3 == 3'b111) begin aluHit = 1'b1; aluOp = 2'b11; end
  end

  always_comb begin
    canCompress = 1'b0;
    cParcel     = 16'h0000;
    case (opcode)
      7'b0010011: begin
        if (inInstruction == 32'h0000_0013) begin
          canCompress = 1'b1;
          cParcel     = 16'h0001;
        end else if (funct3 == 3'b000 && rd == rs1 && rd != 5'd0 && immSmall && imm6 != 6'd0) begin
          canCompress = 1'b1;
          cParcel     = {3'b000, imm6[5], rd, imm6[4:0], 2'b01};
        end else if (funct3 == 3'b111 && rd == rs1 && rdC && immSmall) begin
          canCompress = 1'b1;
          cParcel     = {3'b100, imm6[5], 2'b10, rd[2:0], imm6[4:0], 2'b01};
        end
      end
      7'b0110011: begin
        if (rd == rs1 && funct7 == 7'd0 && funct3 == 3'b000 && rd != 5'd0 && rs2 != 5'd0) begin
          canCompress = 1'b1;
          cParcel     = {4'b1001, rd, rs2, 2'b10};
        end else if (rd == rs1 && rdC && rs2C && aluHit) begin
          canCompress = 1'b1;
          cParcel     = {6'b100011, rd[2:0], aluOp, rs2[2:0], 2'b01};
        end
      end
      7'b0000011: begin
        if (funct3 == 3'b010 && rdC && rs1C && lwOffOk) begin
          canCompress = 1'b1;
          cParcel     = {3'b010, offL[3:1], rs1[2:0], offL[0], offL[4], rd[2:0], 2'b00};
        end
      end
      7'b0100011: begin
        if (funct3 == 3'b010 && rs1C && rs2C && swOffOk) begin
          canCompress = 1'b1;
          cParcel     = {3'b110, offS[3:1], rs1[2:0], offS[0], offS[4], rs2[2:0], 2'b00};
        end
      end
      default: ;
    endcase
  end

  logic slotFree, accept, legal, compressible;

  assign slotFree     = !outValid || outReady;
  assign inReady      = slotFree && !flush;
  assign accept       = inValid && inReady;
  assign legal        = (inInstruction[1:0] == 2'b11);
  assign compressible = ENABLE_COMPACTION && canCompress;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= EMPTY;
      hold           <= '0;
      outWord        <= '0;
      outValid       <= 1'b0;
      illegalInput   <= 1'b0;
      compactedCount <= '0;
    end else begin
      illegalInput <= 1'b0;
      if (outValid && outReady) outValid <= 1'b0;
      if (accept) begin
        if (!legal) begin
          illegalInput <= 1'b1;
        end else if (compressible) begin
          if (compactedCount != '1) compactedCount <= compactedCount + COUNTER_WIDTH'(1);
          if (state == EMPTY) begin
            hold  <= cParcel;
            state <= HALF;
          end else begin
            outWord  <= {cParcel, hold};
            outValid <= 1'b1;
            state    <= EMPTY;
          end
        end else if (state == EMPTY) begin
          outWord  <= inInstruction;
          outValid <= 1'b1;
        end else begin
          // misaligned 32-bit: low half completes this word, high half becomes the new pending parcel
          outWord  <= {inInstruction[15:0], hold};
          hold     <= inInstruction[31:16];
          outValid <= 1'b1;
        end
      end else if (flush && slotFree && state == HALF) begin
        outWord  <= {16'h0001, hold};
        outValid <= 1'b1;
        state    <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_compact_instruction_packer.sv
// Bench for compact_instruction_packer: directed vectors, corner sequences and a randomized
// stream scored against a halfword-queue model of the packer.
module tb_compact_instruction_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        inValid, inReady, flush, outValid, outReady, illegalInput;
  logic [31:0] inInstruction, outWord;
  logic [15:0] compactedCount;

  logic        inReady2, outValid2, illegal2;
  logic [31:0] outWord2;
  logic [1:0]  cnt2;

  logic        inValid0, inReady0, outValid0, illegal0;
  logic [31:0] inInstr0, outWord0;
  logic [15:0] cnt0;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clock = ~clock;

  compact_instruction_packer #(.ENABLE_COMPACTION(1'b1), .COUNTER_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
    .inInstruction(inInstruction), .flush(flush), .outValid(outValid), .outReady(outReady),
    .outWord(outWord), .illegalInput(illegalInput), .compactedCount(compactedCount));

  // narrow counter copy fed the same stream, for saturation
  compact_instruction_packer #(.ENABLE_COMPACTION(1'b1), .COUNTER_WIDTH(2)) dutSat (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady2),
    .inInstruction(inInstruction), .flush(flush), .outValid(outValid2), .outReady(outReady),
    .outWord(outWord2), .illegalInput(illegal2), .compactedCount(cnt2));

  compact_instruction_packer #(.ENABLE_COMPACTION(1'b0), .COUNTER_WIDTH(16)) dutOff (
    .clock(clock), .reset(reset), .inValid(inValid0), .inReady(inReady0),
    .inInstruction(inInstr0), .flush(1'b0), .outValid(outValid0), .outReady(1'b1),
    .outWord(outWord0), .illegalInput(illegal0), .compactedCount(cnt0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // all tasks start and end just after a falling edge
  task automatic send(input logic [31:0] x);
    inInstruction = x;
    inValid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (inReady) break;
      @(negedge clock);
    end
    check("inReadyAtSend", 32'(inReady), 32'd1);
    @(negedge clock);
    inValid = 1'b0;
  endtask

  task automatic expectWord(input string name, input logic [31:0] exp);
    for (int n = 0; n < 20 && !outValid; n++) @(negedge clock);
    check({name, ".valid"}, 32'(outValid), 32'd1);
    check(name, outWord, exp);
  endtask

  task automatic doFlush();
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
  endtask

  function automatic bit isCreg(input int r);
    return r >= 8 && r <= 15;
  endfunction

  // reference compressor: decodes fields to integers and applies the RVC eligibility rules
  function automatic bit refCompress(input logic [31:0] i, output logic [15:0] c);
    int rd, rs1, rs2, f3, f7, immI, immS, op;
    logic [11:0] uI, uS;
    logic [5:0]  i6;
    logic [6:0]  o;
    rd = int'(i[11:7]); rs1 = int'(i[19:15]); rs2 = int'(i[24:20]);
    f3 = int'(i[14:12]); f7 = int'(i[31:25]);
    uI = i[31:20]; uS = {i[31:25], i[11:7]};
    immI = (uI >= 12'd2048) ? int'(uI) - 4096 : int'(uI);
    immS = (uS >= 12'd2048) ? int'(uS) - 4096 : int'(uS);
    c = 16'h0000;
    if (i == 32'h0000_0013) begin c = 16'h0001; return 1'b1; end
    case (i[6:0])
      7'h13: begin
        i6 = uI[5:0];
        if (f3 == 0 && rd == rs1 && rd != 0 && immI >= -32 && immI <= 31 && immI != 0) begin
          c = {3'b000, i6[5], i[11:7], i6[4:0], 2'b01}; return 1'b1;
        end
        if (f3 == 7 && rd == rs1 && isCreg(rd) && immI >= -32 && immI <= 31) begin
          c = {3'b100, i6[5], 2'b10, 3'(rd - 8), i6[4:0], 2'b01}; return 1'b1;
        end
      end
      7'h33: begin
        if (rd == rs1 && f7 == 0 && f3 == 0 && rd != 0 && rs2 != 0) begin
          c = {4'b1001, i[11:7], i[24:20], 2'b10}; return 1'b1;
        end
        op = -1;
        if (f7 == 32 && f3 == 0) op = 0;
        else if (f7 == 0 && f3 == 4) op = 1;
        else if (f7 == 0 && f3 == 6) op = 2;
        else if (f7 == 0 && f3 == 7) op = 3;
        if (rd == rs1 && isCreg(rd) && isCreg(rs2) && op >= 0) begin
          c = {6'b100011, 3'(rd - 8), 2'(op), 3'(rs2 - 8), 2'b01}; return 1'b1;
        end
      end
      7'h03: begin
        if (f3 == 2 && isCreg(rd) && isCreg(rs1) && immI >= 0 && immI <= 124 && immI % 4 == 0) begin
          o = 7'(immI);
          c = {3'b010, o[5:3], 3'(rs1 - 8), o[2], o[6], 3'(rd - 8), 2'b00}; return 1'b1;
        end
      end
      7'h23: begin
        if (f3 == 2 && isCreg(rs2) && isCreg(rs1) && immS >= 0 && immS <= 124 && immS % 4 == 0) begin
          o = 7'(immS);
          c = {3'b110, o[5:3], 3'(rs1 - 8), o[2], o[6], 3'(rs2 - 8), 2'b00}; return 1'b1;
        end
      end
      default: ;
    endcase
    return 1'b0;
  endfunction

  function automatic logic [4:0] pickReg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(8, 15));
  endfunction

  function automatic logic [31:0] genInstr();
    logic [4:0]  a, b, s;
    logic [11:0] im, off;
    logic [6:0]  f7;
    logic [31:0] v;
    a   = pickReg();
    b   = ($urandom_range(0, 2) != 0) ? a : pickReg();
    s   = pickReg();
    im  = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 63)) - 12'd32 : 12'($urandom);
    off = ($urandom_range(0, 2) != 0) ? 12'($urandom_range(0, 33) * 4) : 12'($urandom);
    f7  = ($urandom_range(0, 3) == 0) ? 7'h20 : (($urandom_range(0, 5) == 0) ? 7'h01 : 7'h00);
    v   = $urandom;
    case ($urandom_range(0, 9))
      0:       return {im, b, 3'b000, a, 7'h13};
      1:       return {im, b, 3'b111, a, 7'h13};
      2:       return {f7, s, b, 3'($urandom), a, 7'h33};
      3:       return {off, b, 3'b010, a, 7'h03};
      4:       return {off[11:5], s, b, 3'b010, off[4:0], 7'h23};
      5:       return {v[31:12], a, 7'h37};
      6:       return {v[31:2], 2'($urandom_range(0, 2))};
      7:       return ($urandom_range(0, 1) != 0) ? 32'h0000_0013 : (v | 32'd3);
      default: return {7'h00, s, b, 3'b000, a, 7'h33};
    endcase
  endfunction

  typedef struct {
    logic [31:0] instr;
    bit          comp;
    logic [15:0] parcel;
  } vecT;

  vecT         vecs[15];
  int          expCnt;
  logic [15:0] halves[$];
  logic [31:0] expQ[$];
  logic [15:0] mCnt, cTmp;
  logic        mIll, mValid, slot, acc;

  initial begin
    vecs[0]  = '{32'h00140413, 1'b1, 16'h0405};
    vecs[1]  = '{32'h002080B3, 1'b1, 16'h908A};
    vecs[2]  = '{32'h00452483, 1'b1, 16'h4144};
    vecs[3]  = '{32'h08052483, 1'b0, 16'h0000};
    vecs[4]  = '{32'h00000013, 1'b1, 16'h0001};
    vecs[5]  = '{32'h123452B7, 1'b0, 16'h0000};
    vecs[6]  = '{32'hFE028293, 1'b1, 16'h1281};
    vecs[7]  = '{32'h02028293, 1'b0, 16'h0000};
    vecs[8]  = '{32'hFFF4F493, 1'b1, 16'h98FD};
    vecs[9]  = '{32'h40940433, 1'b1, 16'h8C05};
    vecs[10] = '{32'h0087F7B3, 1'b1, 16'h8FE1};
    vecs[11] = '{32'h06952E23, 1'b1, 16'hDD64};
    vecs[12] = '{32'h01044433, 1'b0, 16'h0000};
    vecs[13] = '{32'h022080B3, 1'b0, 16'h0000};
    vecs[14] = '{32'h00B56533, 1'b1, 16'h8D4D};

    reset = 1'b0; inValid = 1'b0; inInstruction = '0; flush = 1'b0; outReady = 1'b1;
    inValid0 = 1'b0; inInstr0 = '0;
    @(negedge clock); @(negedge clock);
    check("rstOutValid", 32'(outValid), 32'd0);
    check("rstOutWord", outWord, 32'd0);
    check("rstCount", 32'(compactedCount), 32'd0);
    check("rstIllegal", 32'(illegalInput), 32'd0);
    check("rstInReady", 32'(inReady), 32'd1);
    reset = 1'b1;
    @(negedge clock);

    // compaction disabled: compressible input still passes through 32-bit
    inInstr0 = 32'h00140413; inValid0 = 1'b1;
    @(negedge clock);
    inValid0 = 1'b0;
    check("offValid", 32'(outValid0), 32'd1);
    check("offWord", outWord0, 32'h00140413);
    check("offCount", 32'(cnt0), 32'd0);

    send(32'h00140413);
    check("halfNoOutput", 32'(outValid), 32'd0);
    send(32'h002080B3);
    expectWord("pairWord", 32'h908A0405);
    check("pairCount", 32'(compactedCount), 32'd2);
    check("satCountPre", 32'(cnt2), 32'd2);

    expCnt = 2;
    for (int k = 0; k < 15; k++) begin
      send(vecs[k].instr);
      if (vecs[k].comp) begin
        expCnt++;
        doFlush();
        expectWord($sformatf("vec%0d", k), {16'h0001, vecs[k].parcel});
      end else begin
        expectWord($sformatf("vec%0d", k), vecs[k].instr);
      end
    end
    @(negedge clock);
    check("vecCount", 32'(compactedCount), 32'(expCnt));
    check("satCount", 32'(cnt2), 32'd3);

    send(32'h00140413);
    send(32'h123452B7);
    expectWord("misalignWord", 32'h52B70405);
    doFlush();
    expectWord("padWord", 32'h00011234);

    // backpressure: word held, input stalled, nothing lost
    @(negedge clock);
    outReady = 1'b0;
    send(32'h123452B7);
    inInstruction = 32'h0ABCD537; inValid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      check("stallInReady", 32'(inReady), 32'd0);
      check("stallWord", outWord, 32'h123452B7);
      @(negedge clock);
    end
    outReady = 1'b1;
    #1 check("resumeInReady", 32'(inReady), 32'd1);
    @(negedge clock);
    inValid = 1'b0;
    expectWord("resumeWord", 32'h0ABCD537);

    send(32'h0000_0000);
    check("illegalPulse", 32'(illegalInput), 32'd1);
    check("illegalNoWord", 32'(outValid), 32'd0);
    @(negedge clock);
    check("illegalClear", 32'(illegalInput), 32'd0);
    send(32'h00140413);
    send(32'h00140410);
    send(32'h002080B3);
    expectWord("illegalInHalf", 32'h908A0405);

    @(negedge clock);
    flush = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      check("emptyFlushNoWord", 32'(outValid), 32'd0);
      check("flushBlocksIn", 32'(inReady), 32'd0);
    end
    flush = 1'b0;

    send(32'h00140413);
    outReady = 1'b0; flush = 1'b1;
    for (int n = 0; n < 4; n++) @(negedge clock);
    check("heldFlushWord", outWord, 32'h00010405);
    outReady = 1'b1;
    @(negedge clock);
    check("singlePad", 32'(outValid), 32'd0);
    flush = 1'b0;

    // reset while a halfword is pending and a word is unconsumed
    send(32'h00140413);
    outReady = 1'b0;
    send(32'h123452B7);
    check("preRstValid", 32'(outValid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midRstValid", 32'(outValid), 32'd0);
    check("midRstCount", 32'(compactedCount), 32'd0);
    @(negedge clock);
    reset = 1'b1; outReady = 1'b1;
    @(negedge clock);
    send(32'h123452B7);
    expectWord("postRstAligned", 32'h123452B7);
    @(negedge clock);

    mCnt = 16'd0; mIll = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      inValid       = ($urandom_range(0, 3) != 0);
      inInstruction = genInstr();
      flush         = ($urandom_range(0, 15) == 0);
      outReady      = ($urandom_range(0, 3) != 0);
      #1;
      mValid = (expQ.size() != 0);
      check("rndIllegal", 32'(illegalInput), 32'(mIll));
      check("rndOutValid", 32'(outValid), 32'(mValid));
      if (mValid) check("rndWord", outWord, expQ[0]);
      slot = !mValid || outReady;
      check("rndInReady", 32'(inReady), 32'(slot && !flush));
      check("rndCount", 32'(compactedCount), 32'(mCnt));
      acc = inValid && slot && !flush;
      if (mValid && outReady) void'(expQ.pop_front());
      mIll = 1'b0;
      if (acc) begin
        if (inInstruction[1:0] != 2'b11) mIll = 1'b1;
        else if (refCompress(inInstruction, cTmp)) begin
          halves.push_back(cTmp);
          if (mCnt != 16'hFFFF) mCnt++;
        end else begin
          halves.push_back(inInstruction[15:0]);
          halves.push_back(inInstruction[31:16]);
        end
      end else if (flush && slot && halves.size() % 2 == 1) begin
        halves.push_back(16'h0001);
      end
      while (halves.size() >= 2) begin
        expQ.push_back({halves[1], halves[0]});
        void'(halves.pop_front());
        void'(halves.pop_front());
      end
      @(negedge clock);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
